// File: rtl/mm_pkg.sv
// ----------------------------------------------------------------------------
// mm_pkg
// Shared definitions for the Mastermind core and its scorer.
//   state_t   : internal game FSM states
//   PHASE_*   : 2-bit encoding of the externally visible game phase
//   clog2()   : ceiling log2, used to size counters and indices
// No ports (package).
// ----------------------------------------------------------------------------
package mm_pkg;

    // SCORE is internal; externally it is reported as the GUESS phase.
    typedef enum logic [2:0] {
        SECRET,
        GUESS,
        SCORE,
        WIN,
        LOSE
    } state_t;

    localparam logic [1:0] PHASE_SECRET = 2'd0;
    localparam logic [1:0] PHASE_GUESS  = 2'd1;
    localparam logic [1:0] PHASE_WIN    = 2'd2;
    localparam logic [1:0] PHASE_LOSE   = 2'd3;

    // Number of bits needed to encode the values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mm_scorer.sv
// ----------------------------------------------------------------------------
// mm_scorer
// Purely combinational scoring of one guess against the secret.
// Ports:
//   secret  in  N_POS*SYM_W  packed secret, position 0 in the low bits
//   guess   in  N_POS*SYM_W  packed guess, same layout
//   led_pos out N_POS        bit p set when guess[p] == secret[p]
//   exact   out CNT_W        number of exact matches
//   near    out CNT_W        right symbol in the wrong place
// ----------------------------------------------------------------------------
module mm_scorer
    import mm_pkg::*;
#(
    parameter int N_POS = 4,
    parameter int N_SYM = 4
) (
    input  logic [N_POS*clog2(N_SYM)-1:0] secret,
    input  logic [N_POS*clog2(N_SYM)-1:0] guess,
    output logic [N_POS-1:0]              led_pos,
    output logic [clog2(N_POS+1)-1:0]     exact,
    output logic [clog2(N_POS+1)-1:0]     near
);

    localparam int SYM_W = clog2(N_SYM);
    localparam int CNT_W = clog2(N_POS + 1);

    logic [CNT_W-1:0] w_histSecret [N_SYM];
    logic [CNT_W-1:0] w_histGuess  [N_SYM];
    logic [SYM_W-1:0] w_symSecret;
    logic [SYM_W-1:0] w_symGuess;
    logic [CNT_W-1:0] w_exactSum;
    logic [CNT_W-1:0] w_common;
    logic [N_POS-1:0] w_led;

    // Every exact match is also counted in the per-symbol minimum, so the
    // common count is always >= exact and the subtraction cannot underflow.
    always_comb begin
        w_symSecret = '0;
        w_symGuess  = '0;
        w_exactSum  = '0;
        w_common    = '0;
        w_led       = '0;
        for (int s = 0; s < N_SYM; s++) begin
            w_histSecret[s] = '0;
            w_histGuess[s]  = '0;
        end
        for (int p = 0; p < N_POS; p++) begin
            w_symSecret = secret[p*SYM_W +: SYM_W];
            w_symGuess  = guess[p*SYM_W +: SYM_W];
            w_led[p]    = (w_symSecret == w_symGuess);
            w_exactSum  = w_exactSum + {{(CNT_W-1){1'b0}}, w_led[p]};
            w_histSecret[w_symSecret] = w_histSecret[w_symSecret] + 1'b1;
            w_histGuess[w_symGuess]   = w_histGuess[w_symGuess] + 1'b1;
        end
        for (int s = 0; s < N_SYM; s++) begin
            w_common = w_common + ((w_histSecret[s] < w_histGuess[s]) ?
                                   w_histSecret[s] : w_histGuess[s]);
        end
    end

    assign led_pos = w_led;
    assign exact   = w_exactSum;
    assign near    = w_common - w_exactSum;

endmodule

// File: rtl/mastermind_core.sv
// ----------------------------------------------------------------------------
// mastermind_core
// Captures a secret and repeated guesses from a one-hot button bus, scores
// each guess and tracks the attempt count until WIN or LOSE.
// Ports:
//   CLK         in   1      rising-edge clock
//   RESET       in   1      synchronous, active-low reset
//   btn         in   N_SYM  level button bus, bit i = symbol i
//   new_game    in   1      synchronous restart (keeps press history)
//   led_pos     out  N_POS  per-position exact match of the last score
//   exact_cnt   out  CNT_W  exact matches of the last score
//   near_cnt    out  CNT_W  misplaced symbols of the last score
//   tries_used  out  TRY_W  guesses scored this game
//   score_valid out  1      one-cycle pulse when the score outputs update
//   phase       out  2      0 SECRET, 1 GUESS, 2 WIN, 3 LOSE
//   win         out  1      phase == WIN
//   lose        out  1      phase == LOSE
// ----------------------------------------------------------------------------
module mastermind_core
    import mm_pkg::*;
#(
    parameter int N_POS     = 4,
    parameter int N_SYM     = 4,
    parameter int MAX_TRIES = 8
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [N_SYM-1:0]               btn,
    input  logic                           new_game,
    output logic [N_POS-1:0]               led_pos,
    output logic [clog2(N_POS+1)-1:0]      exact_cnt,
    output logic [clog2(N_POS+1)-1:0]      near_cnt,
    output logic [clog2(MAX_TRIES+1)-1:0]  tries_used,
    output logic                           score_valid,
    output logic [1:0]                     phase,
    output logic                           win,
    output logic                           lose
);

    localparam int SYM_W = clog2(N_SYM);
    localparam int CNT_W = clog2(N_POS + 1);
    localparam int TRY_W = clog2(MAX_TRIES + 1);
    localparam int POS_W = clog2(N_POS);

    localparam logic [POS_W-1:0] LAST_POS  = POS_W'(N_POS - 1);
    localparam logic [CNT_W-1:0] ALL_EXACT = CNT_W'(N_POS);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

    state_t                       r_state;
    state_t                       w_nextState;
    logic                         r_btnPrev;
    logic [POS_W-1:0]             r_pos;
    logic [N_POS-1:0][SYM_W-1:0]  r_secret;
    logic [N_POS-1:0][SYM_W-1:0]  r_guess;
    logic [N_POS-1:0]             r_ledPos;
    logic [CNT_W-1:0]             r_exact;
    logic [CNT_W-1:0]             r_near;
    logic [TRY_W-1:0]             r_tries;
    logic                         r_scoreValid;

    logic                         w_press;
    logic [SYM_W-1:0]             w_sym;
    logic [N_POS-1:0]             w_scoreLed;
    logic [CNT_W-1:0]             w_scoreExact;
    logic [CNT_W-1:0]             w_scoreNear;
    logic [TRY_W-1:0]             w_triesNext;
    logic                         w_lastSlot;

    // A press is the first cycle any button is seen after an all-released cycle.
    assign w_press    = (|btn) && !r_btnPrev;
    assign w_lastSlot = (r_pos == LAST_POS);
    assign w_triesNext = (r_tries == TRY_LIMIT) ? r_tries : r_tries + 1'b1;

    // Priority encoder: later iterations overwrite, so the highest set bit wins.
    always_comb begin
        w_sym = '0;
        for (int i = 0; i < N_SYM; i++) begin
            if (btn[i]) begin
                w_sym = SYM_W'(i);
            end
        end
    end

    mm_scorer #(
        .N_POS (N_POS),
        .N_SYM (N_SYM)
    ) u_scorer (
        .secret  (r_secret),
        .guess   (r_guess),
        .led_pos (w_scoreLed),
        .exact   (w_scoreExact),
        .near    (w_scoreNear)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= SECRET;
        end else begin
            r_state <= w_nextState;
        end
    end

    // new_game overrides everything, including a press on the same edge.
    always_comb begin
        w_nextState = r_state;
        if (new_game) begin
            w_nextState = SECRET;
        end else begin
            case (r_state)
                SECRET: if (w_press && w_lastSlot) w_nextState = GUESS;
                GUESS:  if (w_press && w_lastSlot) w_nextState = SCORE;
                SCORE: begin
                    if (w_scoreExact == ALL_EXACT) begin
                        w_nextState = WIN;
                    end else if (w_triesNext == TRY_LIMIT) begin
                        w_nextState = LOSE;
                    end else begin
                        w_nextState = GUESS;
                    end
                end
                WIN:     w_nextState = WIN;
                LOSE:    w_nextState = LOSE;
                default: w_nextState = SECRET;
            endcase
        end
    end

    always_comb begin
        phase = PHASE_SECRET;
        win   = 1'b0;
        lose  = 1'b0;
        case (r_state)
            SECRET:  phase = PHASE_SECRET;
            GUESS:   phase = PHASE_GUESS;
            SCORE:   phase = PHASE_GUESS;
            WIN: begin
                phase = PHASE_WIN;
                win   = 1'b1;
            end
            LOSE: begin
                phase = PHASE_LOSE;
                lose  = 1'b1;
            end
            default: phase = PHASE_SECRET;
        endcase
    end

    // Press history runs in every state and survives new_game so that a button
    // held across a restart or through SCORE/WIN/LOSE never yields a late press.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_btnPrev    <= 1'b0;
            r_pos        <= '0;
            r_secret     <= '0;
            r_guess      <= '0;
            r_ledPos     <= '0;
            r_exact      <= '0;
            r_near       <= '0;
            r_tries      <= '0;
            r_scoreValid <= 1'b0;
        end else begin
            r_btnPrev    <= |btn;
            r_scoreValid <= 1'b0;
            if (new_game) begin
                r_pos    <= '0;
                r_secret <= '0;
                r_guess  <= '0;
                r_ledPos <= '0;
                r_exact  <= '0;
                r_near   <= '0;
                r_tries  <= '0;
            end else begin
                case (r_state)
                    SECRET: begin
                        if (w_press) begin
                            r_secret[r_pos] <= w_sym;
                            r_pos           <= w_lastSlot ? '0 : r_pos + 1'b1;
                        end
                    end
                    GUESS: begin
                        if (w_press) begin
                            r_guess[r_pos] <= w_sym;
                            r_pos          <= w_lastSlot ? '0 : r_pos + 1'b1;
                        end
                    end
                    SCORE: begin
                        r_ledPos     <= w_scoreLed;
                        r_exact      <= w_scoreExact;
                        r_near       <= w_scoreNear;
                        r_tries      <= w_triesNext;
                        r_scoreValid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign led_pos     = r_ledPos;
    assign exact_cnt   = r_exact;
    assign near_cnt    = r_near;
    assign tries_used  = r_tries;
    assign score_valid = r_scoreValid;

endmodule

// File: tb/tb_mastermind_core.sv
// ----------------------------------------------------------------------------
// tb_mastermind_core
// Self-checking bench for mastermind_core. Two instances share clock and
// reset: dut1 uses default parameters, dut2 uses MAX_TRIES = 2 for the LOSE
// path. Expected scores are queued when a guess is issued and popped by a
// monitor whenever the matching instance pulses score_valid.
// ----------------------------------------------------------------------------
module tb_mastermind_core;

    typedef struct {
        logic [3:0] led;
        int         exact;
        int         near;
        int         tries;
        int         phase;
        logic       win;
        logic       lose;
    } exp_t;

    logic       CLK;
    logic       RESET;
    logic [3:0] btn1;
    logic       newGame1;
    logic [3:0] led1;
    logic [2:0] exact1;
    logic [2:0] near1;
    logic [3:0] tries1;
    logic       valid1;
    logic [1:0] phase1;
    logic       win1;
    logic       lose1;

    logic [3:0] btn2;
    logic       newGame2;
    logic [3:0] led2;
    logic [2:0] exact2;
    logic [2:0] near2;
    logic [1:0] tries2;
    logic       valid2;
    logic [1:0] phase2;
    logic       win2;
    logic       lose2;

    int   nVectors = 0;
    int   nFails   = 0;
    exp_t expQ1[$];
    exp_t expQ2[$];

    mastermind_core dut1 (
        .CLK         (CLK),
        .RESET       (RESET),
        .btn         (btn1),
        .new_game    (newGame1),
        .led_pos     (led1),
        .exact_cnt   (exact1),
        .near_cnt    (near1),
        .tries_used  (tries1),
        .score_valid (valid1),
        .phase       (phase1),
        .win         (win1),
        .lose        (lose1)
    );

    mastermind_core #(
        .MAX_TRIES (2)
    ) dut2 (
        .CLK         (CLK),
        .RESET       (RESET),
        .btn         (btn2),
        .new_game    (newGame2),
        .led_pos     (led2),
        .exact_cnt   (exact2),
        .near_cnt    (near2),
        .tries_used  (tries2),
        .score_valid (valid2),
        .phase       (phase2),
        .win         (win2),
        .lose        (lose2)
    );

    // Free-running clock, period 10 time units.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic exp_t mkExp(input logic [3:0] led, input int exact,
                                   input int near, input int tries, input int phase);
        exp_t e;
        e.led   = led;
        e.exact = exact;
        e.near  = near;
        e.tries = tries;
        e.phase = phase;
        e.win   = (phase == 2);
        e.lose  = (phase == 3);
        return e;
    endfunction

    function automatic logic [3:0] symBit(input int s);
        logic [3:0] one;
        one = 4'b0001;
        return one << s;
    endfunction

    // dut1 monitor: every score_valid pulse must match the oldest queued guess.
    always @(negedge CLK) begin : monitorDut1
        exp_t e;
        if (valid1 === 1'b1) begin
            if (expQ1.size() == 0) begin
                checkOutput("dut1 unexpected score_valid", 32'(valid1), 0);
            end else begin
                e = expQ1.pop_front();
                checkOutput("dut1 led_pos", 32'(led1), 32'(e.led));
                checkOutput("dut1 exact_cnt", 32'(exact1), e.exact);
                checkOutput("dut1 near_cnt", 32'(near1), e.near);
                checkOutput("dut1 tries_used", 32'(tries1), e.tries);
                checkOutput("dut1 phase", 32'(phase1), e.phase);
                checkOutput("dut1 win", 32'(win1), 32'(e.win));
                checkOutput("dut1 lose", 32'(lose1), 32'(e.lose));
            end
        end
    end

    // dut2 monitor, same contract as dut1.
    always @(negedge CLK) begin : monitorDut2
        exp_t e;
        if (valid2 === 1'b1) begin
            if (expQ2.size() == 0) begin
                checkOutput("dut2 unexpected score_valid", 32'(valid2), 0);
            end else begin
                e = expQ2.pop_front();
                checkOutput("dut2 led_pos", 32'(led2), 32'(e.led));
                checkOutput("dut2 exact_cnt", 32'(exact2), e.exact);
                checkOutput("dut2 near_cnt", 32'(near2), e.near);
                checkOutput("dut2 tries_used", 32'(tries2), e.tries);
                checkOutput("dut2 phase", 32'(phase2), e.phase);
                checkOutput("dut2 win", 32'(win2), 32'(e.win));
                checkOutput("dut2 lose", 32'(lose2), 32'(e.lose));
            end
        end
    end

    task automatic setBtn(input int which, input logic [3:0] value);
        if (which == 1) btn1 = value;
        else            btn2 = value;
    endtask

    // Drive a button pattern for holdCycles clock edges, then release it.
    task automatic pressBtn(input int which, input logic [3:0] value, input int holdCycles);
        @(posedge CLK); #1;
        setBtn(which, value);
        repeat (holdCycles) @(posedge CLK);
        #1;
        setBtn(which, 4'b0000);
    endtask

    task automatic enterCode(input int which, input int s0, input int s1,
                             input int s2, input int s3);
        pressBtn(which, symBit(s0), 1);
        pressBtn(which, symBit(s1), 1);
        pressBtn(which, symBit(s2), 1);
        pressBtn(which, symBit(s3), 1);
    endtask

    // Wait (bounded) until the monitor has consumed every queued expectation.
    task automatic waitDrain(input int which);
        for (int i = 0; i < 20; i++) begin
            if ((which == 1 ? expQ1.size() : expQ2.size()) == 0) break;
            @(posedge CLK);
        end
        @(posedge CLK); #1;
        if (which == 1) checkOutput("dut1 score arrived", expQ1.size(), 0);
        else            checkOutput("dut2 score arrived", expQ2.size(), 0);
    endtask

    task automatic applyStimulus(input int which, input int s0, input int s1,
                                 input int s2, input int s3, input exp_t e);
        if (which == 1) expQ1.push_back(e);
        else            expQ2.push_back(e);
        enterCode(which, s0, s1, s2, s3);
        waitDrain(which);
    endtask

    task automatic pulseNewGame1();
        @(posedge CLK); #1;
        newGame1 = 1'b1;
        @(posedge CLK); #1;
        newGame1 = 1'b0;
    endtask

    task automatic checkCleared1(input string tag);
        checkOutput({tag, " phase"}, 32'(phase1), 0);
        checkOutput({tag, " led_pos"}, 32'(led1), 0);
        checkOutput({tag, " exact_cnt"}, 32'(exact1), 0);
        checkOutput({tag, " near_cnt"}, 32'(near1), 0);
        checkOutput({tag, " tries_used"}, 32'(tries1), 0);
        checkOutput({tag, " win"}, 32'(win1), 0);
        checkOutput({tag, " lose"}, 32'(lose1), 0);
    endtask

    // Main directed sequence.
    initial begin
        RESET    = 1'b0;
        btn1     = 4'b0000;
        btn2     = 4'b0000;
        newGame1 = 1'b0;
        newGame2 = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkCleared1("reset");
        checkOutput("reset score_valid", 32'(valid1), 0);
        checkOutput("reset dut2 phase", 32'(phase2), 0);
        RESET = 1'b1;

        $display("[TB] test 1: first guess and score latency");
        enterCode(1, 1, 2, 1, 2);
        expQ1.push_back(mkExp(4'b1010, 2, 0, 1, 1));
        pressBtn(1, symBit(2), 1);
        pressBtn(1, symBit(2), 1);
        pressBtn(1, symBit(2), 1);
        @(posedge CLK); #1;
        btn1 = symBit(2);
        @(posedge CLK); #1;
        btn1 = 4'b0000;
        checkOutput("latency valid at press+0", 32'(valid1), 0);
        @(posedge CLK); #1;
        checkOutput("latency valid at press+1", 32'(valid1), 1);
        @(posedge CLK); #1;
        checkOutput("latency valid at press+2", 32'(valid1), 0);
        checkOutput("score held led_pos", 32'(led1), 32'(4'b1010));
        waitDrain(1);

        $display("[TB] test 2: exact-heavy and near-only guesses");
        applyStimulus(1, 3, 2, 1, 2, mkExp(4'b1110, 3, 0, 2, 1));
        applyStimulus(1, 2, 1, 2, 1, mkExp(4'b0000, 0, 4, 3, 1));

        $display("[TB] test 3: win, ignored presses, new_game");
        applyStimulus(1, 1, 2, 1, 2, mkExp(4'b1111, 4, 0, 4, 2));
        enterCode(1, 0, 3, 0, 3);
        repeat (4) @(posedge CLK);
        #1;
        checkOutput("win hold phase", 32'(phase1), 2);
        checkOutput("win hold win", 32'(win1), 1);
        checkOutput("win hold exact_cnt", 32'(exact1), 4);
        checkOutput("win hold tries_used", 32'(tries1), 4);
        checkOutput("win hold led_pos", 32'(led1), 32'(4'b1111));
        pulseNewGame1();
        checkCleared1("new_game");

        $display("[TB] test 5: held buttons give one press");
        enterCode(1, 1, 2, 1, 2);
        expQ1.push_back(mkExp(4'b1110, 3, 0, 1, 1));
        pressBtn(1, 4'b1010, 5);
        pressBtn(1, symBit(2), 1);
        pressBtn(1, symBit(1), 1);
        pressBtn(1, symBit(2), 5);
        waitDrain(1);
        applyStimulus(1, 1, 2, 1, 2, mkExp(4'b1111, 4, 0, 2, 2));

        $display("[TB] test 6: reset mid-guess, new_game with press");
        pulseNewGame1();
        enterCode(1, 1, 2, 1, 2);
        applyStimulus(1, 2, 2, 2, 2, mkExp(4'b1010, 2, 0, 1, 1));
        pressBtn(1, symBit(1), 1);
        pressBtn(1, symBit(2), 1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        checkCleared1("mid-game reset");
        pressBtn(1, symBit(1), 1);
        @(posedge CLK); #1;
        btn1     = symBit(3);
        newGame1 = 1'b1;
        @(posedge CLK); #1;
        btn1     = 4'b0000;
        newGame1 = 1'b0;
        checkOutput("new_game+press phase", 32'(phase1), 0);
        pressBtn(1, symBit(1), 1);
        pressBtn(1, symBit(2), 1);
        pressBtn(1, symBit(1), 1);
        checkOutput("secret 3 of 4 phase", 32'(phase1), 0);
        pressBtn(1, symBit(2), 1);
        checkOutput("secret 4 of 4 phase", 32'(phase1), 1);
        applyStimulus(1, 1, 2, 1, 2, mkExp(4'b1111, 4, 0, 1, 2));

        $display("[TB] test 4: MAX_TRIES = 2 reaches LOSE");
        enterCode(2, 1, 2, 1, 2);
        applyStimulus(2, 2, 2, 2, 2, mkExp(4'b1010, 2, 0, 1, 1));
        applyStimulus(2, 3, 3, 3, 3, mkExp(4'b0000, 0, 0, 2, 3));
        enterCode(2, 1, 2, 1, 2);
        repeat (4) @(posedge CLK);
        #1;
        checkOutput("lose hold lose", 32'(lose2), 1);
        checkOutput("lose hold phase", 32'(phase2), 3);
        checkOutput("lose hold tries_used", 32'(tries2), 2);
        checkOutput("lose hold win", 32'(win2), 0);

        repeat (3) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFails);
        $finish;
    end

endmodule

// File: doc/mastermind_core.md
Name: mastermind_core

Overview:
- Parametrised successor of the 4-position, 4-symbol Mastermind datapath.
- Captures a secret and repeated guesses from a one-hot button bus and scores each guess with exact and near (right symbol, wrong place) counts.
- Tracks the attempt count and ends each game in WIN or LOSE.
- Sits between the button inputs and the LED/display logic, replacing the discrete encoder, decoder, registers and comparators.

Parameters:
N_POS, 4, number of code positions (2..8)
N_SYM, 4, number of symbols, which is the button count (2..16)
MAX_TRIES, 8, guesses allowed before LOSE (1..255)
Derived localparams (not overridable): SYM_W = clog2(N_SYM); CNT_W = clog2(N_POS+1); TRY_W = clog2(MAX_TRIES+1)

Ports:
CLK  in  1  single clock, rising edge
RESET  in  1  synchronous, active-low reset
btn  in  N_SYM  level button bus; bit i = symbol i
new_game  in  1  synchronous restart pulse
led_pos  out  N_POS  bit p = 1 if guess[p] == secret[p] (last scored guess)
exact_cnt  out  CNT_W  popcount of led_pos
near_cnt  out  CNT_W  misplaced-symbol count
tries_used  out  TRY_W  guesses scored this game
score_valid  out  1  one-cycle pulse when the scoring outputs update
phase  out  2  0 = SECRET, 1 = GUESS, 2 = WIN, 3 = LOSE
win  out  1  phase == WIN
lose  out  1  phase == LOSE

Behaviour:
- Reset: RESET = 0 at a CLK edge clears everything.
  - State goes to SECRET.
  - Position index, secret, guess, led_pos, exact_cnt, near_cnt, tries_used, score_valid, win and lose all become 0.
  - Press detector history is cleared.
  - Reset asserted mid-game has the same effect.
- Press detection: a press is registered at an edge where |btn == 1 and |btn was 0 at the previous edge.
  - Holding a button yields exactly one press.
  - If several bits are high, the highest set index is the symbol (priority encode).
  - The history register updates every cycle in every state, so a button held through SCORE/WIN/LOSE never produces a late press.
- FSM states: SECRET, GUESS, SCORE (internal, reported on phase as GUESS), WIN, LOSE.
- SECRET: each press writes the symbol to secret[pos] and increments pos, starting at 0.
  - The press that fills position N_POS-1 resets pos to 0 and moves to GUESS.
- GUESS: each press writes guess[pos], same indexing.
  - The last position moves to SCORE on the same edge.
- SCORE: lasts exactly one cycle; presses during it are discarded. At its exit edge:
  - led_pos, exact_cnt and near_cnt are registered.
  - tries_used increments (saturating at MAX_TRIES).
  - score_valid is high for the following cycle only.
- Next state after SCORE:
  - exact_cnt == N_POS: WIN.
  - Otherwise, new tries_used == MAX_TRIES: LOSE.
  - Otherwise: GUESS.
- Latency: last guess press captured at edge k; scores visible and score_valid = 1 during the cycle after edge k+1.
- near_cnt = sum over symbols s of min(count_secret[s], count_guess[s]) minus exact_cnt. It never underflows.
- Score outputs hold until the next SCORE or until reset/new_game; entering a new guess does not clear them.
- WIN/LOSE: presses are ignored and the state holds until new_game or reset.
- new_game (any state, including mid-entry or SCORE) behaves like reset except the press history is kept.
  - It takes priority over a simultaneous press, and that press is discarded.
- The secret is never driven on any output.

Decomposition:
- Shared package mm_pkg holds:
  - the state enum (SECRET, GUESS, SCORE, WIN, LOSE);
  - the phase encoding constants;
  - a clog2 function.
- Sub-module mm_scorer is purely combinational. It takes the packed secret and guess vectors and returns led_pos, exact and near, using per-symbol histograms.
- The FSM, press detector, storage and counters live in mastermind_core.

Test Plan:
(Defaults unless noted. Symbols are listed for position 0 first. Secret entered as 1,2,1,2 using btn = 4'b0010, 4'b0100, 4'b0010, 4'b0100, released between presses.)
1. Guess 2,2,2,2 -> score_valid pulse 2 cycles after last press; led_pos = 4'b1010, exact = 2, near = 0, tries = 1, phase = GUESS.
2. Guess 3,2,1,2 -> led_pos = 4'b1110, exact = 3, near = 0, tries = 2. Then guess 2,1,2,1 -> led_pos = 0, exact = 0, near = 4, tries = 3.
3. Guess 1,2,1,2 -> exact = 4, win = 1, phase = 2. Further presses leave all outputs unchanged. new_game -> phase = 0, all outputs 0.
4. MAX_TRIES = 2: two wrong guesses -> lose = 1 after second score, tries = 2. Presses ignored thereafter.
5. btn = 4'b1010 held 5 cycles during GUESS -> one press, symbol 3, pos advances by 1. Button held from last guess press through SCORE adds no extra symbol.
6. RESET low mid-guess (2 symbols entered) -> next cycle phase = SECRET, tries = 0, led_pos = 0. new_game simultaneous with a press -> press discarded, pos = 0.
